// File: rtl/skinny_round32_dom1_ctrl_pkg.sv
// skinny_round32_dom1_ctrl_pkg: shared FSM type, default sizes, constants and byte-index helpers
// Byte i of a 128-bit state (row i/4, col i%4) sits at bits [127-8i -: 8]; rows 0-1 of a 64-bit tweakey likewise.
package skinny_round32_dom1_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int ROUNDS_DEF = 40;
    localparam int SB_LAT_DEF = 4;

    // c2 = 0x02 at row 2 col 0 lands in column 2 after ShiftRows; MixColumns copies it to rows 0, 2 and 3
    localparam logic [31:0] C2_MC = 32'h02000202;

    function automatic int byte_lsb(input logic [1:0] row, input logic [1:0] col);
        return 8 * (15 - int'({row, col}));
    endfunction

    // Column c of the ShiftRows output: row j takes col (c-j) mod 4 of the incoming state
    function automatic logic [31:0] sr_column(input logic [127:0] s, input logic [1:0] c);
        logic [31:0] w;
        logic [1:0] sc;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            sc = c - 2'(j);
            w[8*(3-j) +: 8] = s[byte_lsb(2'(j), sc) +: 8];
        end
        return w;
    endfunction

    function automatic logic [127:0] put_column(input logic [127:0] s, input logic [1:0] c, input logic [31:0] v);
        logic [127:0] o;
        o = s;
        for (int j = 0; j < 4; j++) o[byte_lsb(2'(j), c) +: 8] = v[8*(3-j) +: 8];
        return o;
    endfunction

    // Tweakey rows 0-1 after ShiftRows: row 0 stays in col c, row 1 comes from col (c-1) mod 4
    function automatic logic [15:0] tk_pair(input logic [63:0] tk, input logic [1:0] c);
        logic [1:0] cm;
        cm = c - 2'd1;
        return {tk[8*(7-int'(c)) +: 8], tk[8*(3-int'(cm)) +: 8]};
    endfunction

endpackage

// File: rtl/skinny_round32_dom1_ctrl_sel.sv
// skinny_sr_column_sel: selects the ShiftRows diagonal of one column and its tweakey bytes, share by share
// Ports: cur0/cur1 state shares, tk0/tk1 tweakey shares, col column index; si0/si1 column shares, k0/k1 key shares.
module skinny_sr_column_sel
    import skinny_round32_dom1_ctrl_pkg::*;
(
    input  logic [127:0] cur0,
    input  logic [127:0] cur1,
    input  logic [63:0]  tk0,
    input  logic [63:0]  tk1,
    input  logic [1:0]   col,
    output logic [31:0]  si0,
    output logic [31:0]  si1,
    output logic [15:0]  k0,
    output logic [15:0]  k1
);

    assign si0 = sr_column(cur0, col);
    assign si1 = sr_column(cur1, col);
    assign k0  = tk_pair(tk0, col);
    assign k1  = tk_pair(tk1, col);

endmodule

// File: rtl/skinny_round32_dom1_ctrl.sv
// skinny_round32_dom1_ctrl: column-serial DOM1 Skinny-128-384+ round controller driving an external 32-bit superbox
// Ports: clk, rst (sync, active high); start, st_in0/1 plaintext shares; tk0/1 round tweakey shares (rows 0-1);
//        rnd fresh randomness; so0/1 superbox result; si0/1, k0/1, r superbox operands; rnd_req randomness strobe;
//        round_o round index; busy while running; done one-cycle pulse; st_out0/1 ciphertext shares.
module skinny_round32_dom1_ctrl
    import skinny_round32_dom1_ctrl_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF,
    parameter int SB_LAT = SB_LAT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] st_in0,
    input  logic [127:0] st_in1,
    input  logic [63:0]  tk0,
    input  logic [63:0]  tk1,
    input  logic [31:0]  rnd,
    input  logic [31:0]  so0,
    input  logic [31:0]  so1,
    output logic [31:0]  si0,
    output logic [31:0]  si1,
    output logic [15:0]  k0,
    output logic [15:0]  k1,
    output logic [31:0]  r,
    output logic         rnd_req,
    output logic [5:0]   round_o,
    output logic         busy,
    output logic         done,
    output logic [127:0] st_out0,
    output logic [127:0] st_out1
);

    localparam int WW = $clog2(SB_LAT + 1);

    state_e        state_q, state_d;
    logic [5:0]    round_q, round_d;
    logic [1:0]    col_q, col_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [127:0]  cur0_q, cur0_d, cur1_q, cur1_d;
    logic [127:0]  nxt0_q, nxt0_d, nxt1_q, nxt1_d;
    logic [127:0]  out0_q, out0_d, out1_q, out1_d;
    logic [31:0]   si0_q, si0_d, si1_q, si1_d, r_q, r_d;
    logic [15:0]   k0_q, k0_d, k1_q, k1_d;
    logic [31:0]   sel_si0, sel_si1;
    logic [15:0]   sel_k0, sel_k1;
    logic          issue, capture;

    skinny_sr_column_sel u_sel (
        .cur0 (cur0_q),
        .cur1 (cur1_q),
        .tk0  (tk0),
        .tk1  (tk1),
        .col  (col_q),
        .si0  (sel_si0),
        .si1  (sel_si1),
        .k0   (sel_k0),
        .k1   (sel_k1)
    );

    // Operands are latched on the first cycle of a column and held until the superbox result is taken
    assign issue   = state_q == RUN && wcnt_q == '0;
    assign capture = state_q == RUN && wcnt_q == WW'(SB_LAT);

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        col_d   = col_q;
        wcnt_d  = wcnt_q;
        cur0_d  = cur0_q;
        cur1_d  = cur1_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        si0_d   = issue ? sel_si0 : si0_q;
        si1_d   = issue ? sel_si1 : si1_q;
        k0_d    = issue ? sel_k0 : k0_q;
        k1_d    = issue ? sel_k1 : k1_q;
        r_d     = issue ? rnd : r_q;
        nxt0_d  = capture ? put_column(nxt0_q, col_q, so0 ^ (col_q == 2'd2 ? C2_MC : 32'h0)) : nxt0_q;
        nxt1_d  = capture ? put_column(nxt1_q, col_q, so1) : nxt1_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                cur0_d  = st_in0;
                cur1_d  = st_in1;
                round_d = '0;
                col_d   = '0;
                wcnt_d  = '0;
            end
            RUN: begin
                wcnt_d = capture ? '0 : wcnt_q + WW'(1);
                col_d  = capture ? col_q + 2'd1 : col_q;
                if (capture && col_q == 2'd3) begin
                    cur0_d = nxt0_d;
                    cur1_d = nxt1_d;
                    if (round_q == 6'(ROUNDS - 1)) begin
                        state_d = DONE;
                        out0_d  = nxt0_d;
                        out1_d  = nxt1_d;
                    end else begin
                        round_d = round_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            col_q   <= '0;
            wcnt_q  <= '0;
            cur0_q  <= '0;
            cur1_q  <= '0;
            nxt0_q  <= '0;
            nxt1_q  <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            si0_q   <= '0;
            si1_q   <= '0;
            k0_q    <= '0;
            k1_q    <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            col_q   <= col_d;
            wcnt_q  <= wcnt_d;
            cur0_q  <= cur0_d;
            cur1_q  <= cur1_d;
            nxt0_q  <= nxt0_d;
            nxt1_q  <= nxt1_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            si0_q   <= si0_d;
            si1_q   <= si1_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            r_q     <= r_d;
        end
    end

    assign si0     = si0_q;
    assign si1     = si1_q;
    assign k0      = k0_q;
    assign k1      = k1_q;
    assign r       = r_q;
    assign rnd_req = issue;
    assign round_o = round_q;
    assign busy    = state_q == RUN;
    assign done    = state_q == DONE;
    assign st_out0 = out0_q;
    assign st_out1 = out1_q;

endmodule

// File: tb/tb_skinny_round32_dom1_ctrl.sv
// tb_skinny_round32_dom1_ctrl: directed bench with a superbox stand-in and a full-state Skinny round model
module tb_skinny_round32_dom1_ctrl;

    logic         clk = 1'b0;
    logic         rst, start, tk_mask;
    logic [127:0] st_in0, st_in1, st_out0, st_out1;
    logic [63:0]  tk0, tk1;
    logic [31:0]  rnd, so0, so1, si0, si1, r;
    logic [15:0]  k0, k1;
    logic         rnd_req, busy, done;
    logic [5:0]   round_o;

    logic         start_b, rnd_req_b, busy_b, done_b;
    logic [127:0] st_out0_b, st_out1_b;
    logic [31:0]  so0_b, so1_b, si0_b, si1_b, r_b;
    logic [15:0]  k0_b, k1_b;
    logic [5:0]   round_o_b;

    logic [127:0] pipe [0:2];
    int           n_chk = 0;
    int           n_fail = 0;
    logic         r_pending;
    logic [31:0]  exp_r;

    always #5 clk = ~clk;

    skinny_round32_dom1_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .st_in0(st_in0), .st_in1(st_in1),
        .tk0(tk0), .tk1(tk1), .rnd(rnd), .so0(so0), .so1(so1),
        .si0(si0), .si1(si1), .k0(k0), .k1(k1), .r(r), .rnd_req(rnd_req),
        .round_o(round_o), .busy(busy), .done(done), .st_out0(st_out0), .st_out1(st_out1)
    );

    skinny_round32_dom1_ctrl #(.ROUNDS(1), .SB_LAT(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .st_in0(128'h0), .st_in1(128'h0),
        .tk0(64'h0), .tk1(64'h0), .rnd(32'h0), .so0(so0_b), .so1(so1_b),
        .si0(si0_b), .si1(si1_b), .k0(k0_b), .k1(k1_b), .r(r_b), .rnd_req(rnd_req_b),
        .round_o(round_o_b), .busy(busy_b), .done(done_b), .st_out0(st_out0_b), .st_out1(st_out1_b)
    );

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x, y;
        x = ~a;
        x ^= ((x >> 2) & (x >> 3)) & 8'h11;
        y = ((x << 5) & (x << 1)) & 8'h20;
        x ^= (((x << 5) & (x << 4)) & 8'h40) ^ y;
        y = ((x << 2) & (x << 1)) & 8'h80;
        x ^= (((x >> 2) & (x << 1)) & 8'h02) ^ y;
        y = ((x >> 5) & (x << 1)) & 8'h04;
        x ^= (((x >> 1) & (x >> 2)) & 8'h08) ^ y;
        x = ~x;
        return ((x & 8'h08) << 1) | ((x & 8'h32) << 2) | ((x & 8'h01) << 5) |
               ((x & 8'h80) >> 6) | ((x & 8'h40) >> 4) | ((x & 8'h04) >> 2);
    endfunction

    function automatic logic [63:0] tk_base(input logic [5:0] rr);
        return 64'h9e3779b97f4a7c15 * 64'(rr) + 64'h0123456789abcdef;
    endfunction

    function automatic logic [63:0] tk_msk(input logic [5:0] rr);
        return 64'hc2b2ae3d27d4eb4f * (64'(rr) + 64'd1);
    endfunction

    // Unmasked superbox: SubCells, tweakey on rows 0-1, MixColumns on a single column
    function automatic logic [31:0] sb_fn(input logic [31:0] x, input logic [15:0] k);
        logic [7:0] b0, b1, b2, b3;
        b0 = sbox(x[31:24]) ^ k[15:8];
        b1 = sbox(x[23:16]) ^ k[7:0];
        b2 = sbox(x[15:8]);
        b3 = sbox(x[7:0]);
        return {b0 ^ b2 ^ b3, b0, b1 ^ b2, b0 ^ b2};
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [63:0]  tk;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int rr = 0; rr < nr; rr++) begin
            tk = tk_base(6'(rr));
            for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
            for (int i = 0; i < 8; i++) s[i] ^= tk[63-8*i -: 8];
            s[8] ^= 8'h02;
            for (int i = 0; i < 4; i++)
                for (int c = 0; c < 4; c++) t[4*i+c] = s[4*i+((c-i+4)%4)];
            for (int c = 0; c < 4; c++) begin
                s[c]    = t[c] ^ t[8+c] ^ t[12+c];
                s[4+c]  = t[c];
                s[8+c]  = t[4+c] ^ t[8+c];
                s[12+c] = t[c] ^ t[8+c];
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    always_comb begin
        tk1 = tk_mask ? tk_msk(round_o) : 64'h0;
        tk0 = tk_base(round_o) ^ tk1;
    end

    // Superbox stand-in with SB_LAT-1 register stages; output remasked with r
    always @(posedge clk) begin
        pipe[0] <= {si0, si1, k0, k1, r};
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign so0 = sb_fn(pipe[2][127:96] ^ pipe[2][95:64], pipe[2][63:48] ^ pipe[2][47:32]) ^ pipe[2][31:0];
    assign so1 = pipe[2][31:0];

    assign so0_b = sb_fn(si0_b ^ si1_b, k0_b ^ k1_b) ^ r_b;
    assign so1_b = r_b;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [127:0] p0, input logic [127:0] p1, input logic msk,
                       input logic hold, output int lat, output int nreq);
        st_in0 = p0;
        st_in1 = p1;
        tk_mask = msk;
        start = 1'b1;
        lat = 0;
        nreq = 0;
        r_pending = 1'b0;
        rnd = msk ? $urandom : 32'h0;
        do begin
            @(negedge clk);
            start = hold;
            lat++;
            if (r_pending) begin
                chk("r_latch", 128'(r), 128'(exp_r));
                r_pending = 1'b0;
            end
            if (rnd_req) nreq++;
            rnd = msk ? $urandom : 32'h0;
            if (rnd_req && nreq == 1) begin
                exp_r = rnd;
                r_pending = 1'b1;
            end
        end while (!done && lat < 2000);
    endtask

    initial begin
        int lat, nreq, n;
        logic [127:0] m, pa, pb, exp_a, exp_b;
        rst = 1'b1;
        start = 1'b0;
        start_b = 1'b0;
        st_in0 = '0;
        st_in1 = '0;
        rnd = '0;
        tk_mask = 1'b0;
        pa = 128'ha3994b66ad85a3459f44e92b08f550cb;
        pb = 128'h00112233445566778899aabbccddeeff;
        exp_a = ref_enc(pa, 40);
        exp_b = ref_enc(pb, 40);
        repeat (2) @(negedge clk);
        chk("rst_busy", 128'(busy), '0);
        chk("rst_done", 128'(done), '0);
        chk("rst_rnd_req", 128'(rnd_req), '0);
        chk("rst_round", 128'(round_o), '0);
        chk("rst_sb_ports", {si0, si1, k0, k1, r}, '0);
        chk("rst_out0", st_out0, '0);
        chk("rst_out1", st_out1, '0);
        rst = 1'b0;
        @(negedge clk);
        run(pa, '0, 1'b0, 1'b0, lat, nreq);
        chk("plain_latency", 128'(lat), 128'(801));
        chk("plain_out0", st_out0, exp_a);
        chk("plain_out1", st_out1, '0);
        chk("plain_rnd_reqs", 128'(nreq), 128'(160));
        chk("done_busy", 128'(busy), '0);
        @(negedge clk);
        chk("done_pulse", 128'(done), '0);
        chk("idle_busy", 128'(busy), '0);
        repeat (4) @(negedge clk);
        chk("out_held", st_out0, exp_a);
        m = {$urandom, $urandom, $urandom, $urandom};
        run(pa ^ m, m, 1'b1, 1'b0, lat, nreq);
        chk("masked_latency", 128'(lat), 128'(801));
        chk("masked_xor", st_out0 ^ st_out1, exp_a);
        @(negedge clk);
        run(pb, '0, 1'b0, 1'b0, lat, nreq);
        chk("plain_b_out0", st_out0, exp_b);
        @(negedge clk);
        st_in0 = pa;
        st_in1 = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (round_o != 6'd17 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_round17", 128'(round_o), 128'(17));
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 128'(busy), '0);
        chk("midrst_rnd_req", 128'(rnd_req), '0);
        chk("midrst_round", 128'(round_o), '0);
        chk("midrst_sb_ports", {si0, si1, k0, k1, r}, '0);
        chk("midrst_out0", st_out0, '0);
        m = {$urandom, $urandom, $urandom, $urandom};
        run(pb ^ m, m, 1'b1, 1'b0, lat, nreq);
        chk("after_rst_xor", st_out0 ^ st_out1, exp_b);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("rst_start_busy", 128'(busy), '0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_idle", 128'(busy), '0);
        run(pa, '0, 1'b0, 1'b1, lat, nreq);
        chk("hold_latency", 128'(lat), 128'(801));
        chk("hold_out0", st_out0, exp_a);
        chk("hold_done_busy", 128'(busy), '0);
        @(negedge clk);
        chk("hold_done_pulse", 128'(done), '0);
        chk("hold_idle_busy", 128'(busy), '0);
        @(negedge clk);
        chk("hold_restart", 128'(busy), 128'(1));
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_b = 1'b1;
        lat = 0;
        nreq = 0;
        do begin
            @(negedge clk);
            start_b = 1'b0;
            lat++;
            if (rnd_req_b) nreq++;
        end while (!done_b && lat < 100);
        chk("r1_latency", 128'(lat), 128'(21));
        chk("r1_rnd_reqs", 128'(nreq), 128'(4));
        chk("r1_out0", st_out0_b, 128'h65656765656565650000020000000200);
        chk("r1_out1", st_out1_b, '0);
        chk("r1_round", 128'(round_o_b), '0);
        chk("r1_busy", 128'(busy_b), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
